key_debounce_encoder: RTL and testbench
=======================================

// Module: key_debounce_encoder
// PURPOSE
//  Upstream input stage for textlcd. Synchronises and debounces the raw push
//  buttons swp0..swp9 and lrd, encodes them, and emits one single-cycle
//  key_valid strobe per clean press. The calculator datapath and LCD logic
//  see one event per physical press, never bounce or auto-repeat.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000  consecutive stable clk cycles required (press and release); min 2
//  CNT_W            16    debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk        in   1      system clock, single clock domain
//  rst        in   1      asynchronous, active-high reset
//  swp0..swp9 in   1 ea   raw digit buttons, active-high, asynchronous to clk
//  lrd        in   1      raw function button, active-high, asynchronous
//  key_valid  out  1      one-clk strobe: debounced press accepted
//  key_code   out  4      0..9 = swp0..swp9, 4'hA = lrd; held until next strobe
//  key_held   out  1      high while an accepted key is still physically down
//  key_err    out  1      one-clk strobe: >1 button stable together (rejected)
// BEHAVIOUR
//  - Reset (async, rst=1): all sync flops 0, counter 0, state IDLE,
//    key_valid=0, key_code=4'h0, key_held=0, key_err=0. Clean restart on deassert.
//  - Input path: every button through its own 2-flop synchroniser (11 bits).
//    Downstream logic uses only synchronised bits.
//  - sync vector classes: NONE (all 0), ONE (exactly one bit), MULTI (>=2 bits).
//  - State machine:
//    IDLE:   class != NONE -> capture vector, cnt=1, go PRESS.
//    PRESS:  vector == captured -> cnt++. Vector changes but != NONE -> recapture, cnt=1.
//            Vector goes NONE -> IDLE, no strobe.
//            When cnt reaches DEBOUNCE_CYCLES: ONE -> key_valid=1 for that cycle,
//            key_code updated same cycle, key_held=1, go HELD.
//            MULTI -> key_err=1 for that cycle, go HELD; key_held stays 0 and
//            key_code keeps its old value.
//    HELD:   vector NONE -> cnt=1, go RELEASE. Other changes ignored:
//            no new strobe and no code update.
//    RELEASE: vector NONE -> cnt++. Vector != NONE -> go HELD (bounce), no strobe.
//            At cnt == DEBOUNCE_CYCLES -> key_held=0, go IDLE.
//  - Latency: a button rising before clk edge E0 and held clean gives key_valid
//    high in the cycle after edge E0+2+DEBOUNCE_CYCLES. That is exactly
//    DEBOUNCE_CYCLES+3 edges after E0, with no jitter.
//  - Strobes are registered outputs, high for exactly one clk.
//    key_valid and key_err are never high together.
//  - Release: key_held falls DEBOUNCE_CYCLES+3 edges after the button falls.
//    A new press is accepted only from IDLE, so no auto-repeat.
//  - The counter saturates at DEBOUNCE_CYCLES and never wraps.
//  - Reset mid-PRESS or mid-HELD: no strobe. After reset, a still-held button
//    is debounced from scratch and produces exactly one key_valid.
// TESTING
//  1. DEBOUNCE_CYCLES=8. Clean swp7 pulse of 40 cycles -> one key_valid,
//     11 edges after the rise, key_code=7. key_held falls 11 edges after the fall.
//  2. swp5 bounces 1/0 every 3 cycles for 30 cycles, then stays high
//     -> exactly one key_valid, code 5, 11 edges after the last rising edge.
//  3. swp1 and swp2 rise together and hold 20 cycles -> key_err once,
//     no key_valid, key_code unchanged, key_held=0.
//  4. swp3 accepted. While held, swp9 is added and later both are released
//     -> no second strobe, code stays 3. A later clean lrd press -> key_valid, code 4'hA.
//  5. rst asserted 2 cycles into debouncing swp4, then released with swp4 still high
//     -> no strobe during reset, one key_valid (code 4) DEBOUNCE_CYCLES+3 edges after rst falls.
//  6. Release bounce: swp6 is accepted, then drops for 4 cycles, returns high,
//     then releases cleanly -> key_held stays 1 through the bounce, no extra strobe.

Source files
------------

// File: rtl/key_debounce_encoder_if.sv
// Button/key bundle between the raw push buttons and the debounced key event outputs.
// The master drives the raw buttons and the slave (the debouncer) drives the key outputs.
interface key_debounce_encoder_if;
    logic       i_swp0;
    logic       i_swp1;
    logic       i_swp2;
    logic       i_swp3;
    logic       i_swp4;
    logic       i_swp5;
    logic       i_swp6;
    logic       i_swp7;
    logic       i_swp8;
    logic       i_swp9;
    logic       i_lrd;
    logic       o_key_valid;
    logic [3:0] o_key_code;
    logic       o_key_held;
    logic       o_key_err;

    modport master (
        output i_swp0, i_swp1, i_swp2, i_swp3, i_swp4,
        output i_swp5, i_swp6, i_swp7, i_swp8, i_swp9, i_lrd,
        input  o_key_valid, o_key_code, o_key_held, o_key_err
    );

    modport slave (
        input  i_swp0, i_swp1, i_swp2, i_swp3, i_swp4,
        input  i_swp5, i_swp6, i_swp7, i_swp8, i_swp9, i_lrd,
        output o_key_valid, o_key_code, o_key_held, o_key_err
    );
endinterface

// File: rtl/key_debounce_encoder.sv
// Synchronises and debounces swp0..swp9 and lrd, then emits one key_valid strobe per clean press
// (or one key_err strobe when several buttons settle together).
module key_debounce_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input logic                   clk,
    input logic                   rst,
    key_debounce_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    logic [10:0]      w_raw;
    logic [10:0]      r_meta;
    logic [10:0]      r_sync;
    logic             w_is_none;
    logic             w_is_one;
    logic [3:0]       w_enc;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [10:0]      r_cap;
    logic [10:0]      w_cap_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_held;
    logic             w_held_nxt;
    logic [3:0]       r_code;
    logic [3:0]       w_code_nxt;

    assign w_raw = {bus.i_lrd,  bus.i_swp9, bus.i_swp8, bus.i_swp7, bus.i_swp6,
                    bus.i_swp5, bus.i_swp4, bus.i_swp3, bus.i_swp2, bus.i_swp1,
                    bus.i_swp0};

    // Each button gets its own two-flop synchroniser; nothing downstream sees w_raw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 11'd0;
            r_sync <= 11'd0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    assign w_is_none = (r_sync == 11'd0);
    assign w_is_one  = !w_is_none && ((r_sync & (r_sync - 11'd1)) == 11'd0);
    assign w_cnt_inc = (r_cnt >= LP_MAX) ? LP_MAX : r_cnt + LP_ONE;

    always_comb begin
        w_enc = 4'h0;
        for (int i = 0; i < 11; i++) begin
            if (r_sync[i]) w_enc = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cap   <= 11'd0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_held  <= 1'b0;
            r_code  <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_cap_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_held  <= w_held_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // A press counts only while the captured vector stays identical; a full
    // count checked on the next stable cycle gives the strobe, which is then
    // registered so the outputs are glitch-free one-cycle pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_held_nxt  = r_held;
        w_code_nxt  = r_code;
        case (r_state)
            S_IDLE: begin
                if (!w_is_none) begin
                    w_cap_nxt   = r_sync;
                    w_cnt_nxt   = LP_ONE;
                    w_state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (w_is_none) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_sync != r_cap) begin
                    w_cap_nxt = r_sync;
                    w_cnt_nxt = LP_ONE;
                end else if (r_cnt == LP_MAX) begin
                    if (w_is_one) begin
                        w_valid_nxt = 1'b1;
                        w_code_nxt  = w_enc;
                        w_held_nxt  = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_HELD;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_HELD: begin
                if (w_is_none) begin
                    w_cnt_nxt   = LP_ONE;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!w_is_none) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == LP_MAX) begin
                    w_held_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_key_valid = r_valid;
    assign bus.o_key_err   = r_err;
    assign bus.o_key_held  = r_held;
    assign bus.o_key_code  = r_code;

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Bench for key_debounce_encoder: directed scenarios plus random button segments, checked every
// cycle against a sliding-window model of the debounce rules.
module tb_key_debounce_encoder;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] raw;

    int checks   = 0;
    int failures = 0;
    int edgeNo   = 0;

    // Sliding-window reference model state
    logic [10:0] p1;
    logic [10:0] p2;
    logic [10:0] win[$];
    bit          waitRelease;
    logic        expValid;
    logic        expErr;
    logic        expHeld;
    logic [3:0]  expCode;

    // Observation bookkeeping for the directed latency/count checks
    int   validCount = 0;
    int   errCount   = 0;
    int   lastValidEdge = -1;
    int   lastHeldFallEdge = -1;
    logic prevHeld = 1'b0;

    key_debounce_encoder_if bus ();

    key_debounce_encoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.i_swp0 = raw[0];
    assign bus.i_swp1 = raw[1];
    assign bus.i_swp2 = raw[2];
    assign bus.i_swp3 = raw[3];
    assign bus.i_swp4 = raw[4];
    assign bus.i_swp5 = raw[5];
    assign bus.i_swp6 = raw[6];
    assign bus.i_swp7 = raw[7];
    assign bus.i_swp8 = raw[8];
    assign bus.i_swp9 = raw[9];
    assign bus.i_lrd  = raw[10];

    function automatic logic [10:0] bitOf(input int i);
        logic [10:0] one;
        one = 11'd1;
        return one << i;
    endfunction

    function automatic int popc(input logic [10:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 11; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic resetModel();
        p1 = 11'd0;
        p2 = 11'd0;
        win.delete();
        waitRelease = 1'b0;
        expValid = 1'b0;
        expErr   = 1'b0;
        expHeld  = 1'b0;
        expCode  = 4'h0;
    endtask

    // A key event happens when the last D+1 synchronised samples, all taken
    // after the previous event, agree: a non-zero vector while waiting for a
    // press, all-zero while waiting for a release.
    task automatic modelStep();
        logic [10:0] s;
        bit same;
        s  = p2;
        p2 = p1;
        p1 = raw;
        expValid = 1'b0;
        expErr   = 1'b0;
        win.push_back(s);
        if (win.size() > D + 1) void'(win.pop_front());
        if (win.size() == D + 1) begin
            same = 1'b1;
            for (int i = 1; i < win.size(); i++) if (win[i] !== win[0]) same = 1'b0;
            if (same && !waitRelease && win[0] != 11'd0) begin
                if (popc(win[0]) == 1) begin
                    expValid = 1'b1;
                    expHeld  = 1'b1;
                    for (int i = 0; i < 11; i++) if (win[0][i]) expCode = 4'(i);
                end else begin
                    expErr = 1'b1;
                end
                waitRelease = 1'b1;
                win.delete();
            end else if (same && waitRelease && win[0] == 11'd0) begin
                expHeld = 1'b0;
                waitRelease = 1'b0;
                win.delete();
            end
        end
    endtask

    task automatic checkOutput();
        checks++;
        assert ({bus.o_key_valid, bus.o_key_err, bus.o_key_held, bus.o_key_code}
                === {expValid, expErr, expHeld, expCode})
        else begin
            failures++;
            $error("FAIL outputs edge=%0d observed valid/err/held/code=%b/%b/%b/%h expected %b/%b/%b/%h",
                   edgeNo, bus.o_key_valid, bus.o_key_err, bus.o_key_held, bus.o_key_code,
                   expValid, expErr, expHeld, expCode);
        end
        if (bus.o_key_valid === 1'b1) begin
            validCount++;
            lastValidEdge = edgeNo;
        end
        if (bus.o_key_err === 1'b1) errCount++;
        if (prevHeld === 1'b1 && bus.o_key_held === 1'b0) lastHeldFallEdge = edgeNo;
        prevHeld = bus.o_key_held;
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: model advances on the edge, outputs are sampled 1ns later,
    // and control returns at the falling edge where inputs may change.
    task automatic tick();
        @(posedge clk);
        edgeNo++;
        if (!rst) modelStep();
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [10:0] v, input int n);
        raw = v;
        repeat (n) tick();
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        resetModel();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int vc0;
        int ec0;
        int riseEdge;
        int a;
        int b;
        int sel;
        logic [10:0] v;

        raw = 11'd0;
        doReset(3);
        checkValue("reset_code", int'(bus.o_key_code), 0);
        checkValue("reset_held", int'(bus.o_key_held), 0);

        $display("[TB] clean swp7 press");
        applyStimulus(11'd0, 5);
        vc0 = validCount;
        riseEdge = edgeNo + 1;
        applyStimulus(bitOf(7), 40);
        checkValue("t1_count", validCount - vc0, 1);
        checkValue("t1_latency_edges", lastValidEdge - riseEdge + 1, D + 3);
        checkValue("t1_code", int'(bus.o_key_code), 7);
        riseEdge = edgeNo + 1;
        applyStimulus(11'd0, 20);
        checkValue("t1_release_edges", lastHeldFallEdge - riseEdge + 1, D + 3);

        $display("[TB] bouncing swp5");
        vc0 = validCount;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(bitOf(5), 3);
            applyStimulus(11'd0, 3);
        end
        riseEdge = edgeNo + 1;
        applyStimulus(bitOf(5), 30);
        checkValue("t2_count", validCount - vc0, 1);
        checkValue("t2_latency_edges", lastValidEdge - riseEdge + 1, D + 3);
        checkValue("t2_code", int'(bus.o_key_code), 5);
        applyStimulus(11'd0, 20);

        $display("[TB] swp1+swp2 together");
        vc0 = validCount;
        ec0 = errCount;
        applyStimulus(bitOf(1) | bitOf(2), 20);
        checkValue("t3_err_count", errCount - ec0, 1);
        checkValue("t3_valid_count", validCount - vc0, 0);
        checkValue("t3_code", int'(bus.o_key_code), 5);
        checkValue("t3_held", int'(bus.o_key_held), 0);
        applyStimulus(11'd0, 20);

        $display("[TB] swp3 held, swp9 added, then lrd");
        vc0 = validCount;
        applyStimulus(bitOf(3), 20);
        applyStimulus(bitOf(3) | bitOf(9), 15);
        applyStimulus(11'd0, 20);
        checkValue("t4_count", validCount - vc0, 1);
        checkValue("t4_code", int'(bus.o_key_code), 3);
        applyStimulus(bitOf(10), 20);
        checkValue("t4_count_lrd", validCount - vc0, 2);
        checkValue("t4_code_lrd", int'(bus.o_key_code), 10);
        applyStimulus(11'd0, 20);

        $display("[TB] reset during swp4 debounce");
        vc0 = validCount;
        applyStimulus(bitOf(4), 4);
        doReset(3);
        checkValue("t5_count_reset", validCount - vc0, 0);
        riseEdge = edgeNo + 1;
        applyStimulus(bitOf(4), 20);
        checkValue("t5_count", validCount - vc0, 1);
        checkValue("t5_latency_edges", lastValidEdge - riseEdge + 1, D + 3);
        checkValue("t5_code", int'(bus.o_key_code), 4);
        applyStimulus(11'd0, 20);

        $display("[TB] release bounce on swp6");
        vc0 = validCount;
        applyStimulus(bitOf(6), 20);
        applyStimulus(11'd0, 4);
        applyStimulus(bitOf(6), 10);
        checkValue("t6_held_through_bounce", int'(bus.o_key_held), 1);
        applyStimulus(11'd0, 20);
        checkValue("t6_count", validCount - vc0, 1);
        checkValue("t6_held_after", int'(bus.o_key_held), 0);

        $display("[TB] random segments");
        for (int seg = 0; seg < 300; seg++) begin
            sel = int'($urandom_range(0, 9));
            a = int'($urandom_range(0, 10));
            b = (a + 1 + int'($urandom_range(0, 9))) % 11;
            if (sel <= 2)      v = 11'd0;
            else if (sel <= 7) v = bitOf(a);
            else               v = bitOf(a) | bitOf(b);
            if ($urandom_range(0, 39) == 0) doReset(int'($urandom_range(1, 3)));
            applyStimulus(v, int'($urandom_range(1, 2 * D + 4)));
        end
        applyStimulus(11'd0, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
